stopwatch_ctrl: RTL and testbench

//  Sequencer for four cascaded n_counter digits forming a 00.00-59.99 s stopwatch.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/n_counter.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit geometry for the stopwatch sequencer
package stopwatch_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} sw_state_t;

   localparam int DIGITS = 4;
   localparam int BCD_W  = 4;
   localparam int RADIX [DIGITS] = '{10, 10, 10, 6};

   // Terminal count of digit i, sized to a BCD digit.
   function automatic logic [BCD_W-1:0] digit_max(input int i);
      return BCD_W'(RADIX[i] - 1);
   endfunction

endpackage

// File: rtl/n_counter.sv
// rtl/n_counter.sv - modulo-RADIX counter digit with synchronous clear and carry-out
module n_counter #(
   parameter int RADIX = 10,
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             count,
   output logic [WIDTH-1:0] q,
   output logic             co
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(RADIX - 1);

   assign co = count && (q == MAX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (count) begin
         q <= (q == MAX) ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - 00.00-59.99 s stopwatch sequencer: FSM, 1/100 s prescaler, digit carries
// Optional lap freeze of the display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic        running,
   output logic        overflow,
   output logic [15:0] display
);

   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   sw_state_t               state;
   logic [PW-1:0]           presc;
   logic                    tick;
   logic [BCD_W-1:0]        q [DIGITS];
   logic [DIGITS-1:0]       count;
   logic [DIGITS-1:0]       co;
   logic [DIGITS*BCD_W-1:0] live;
   logic                    wrap;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         running <= 1'b0;
      end else if (clear) begin
         state   <= ST_IDLE;
         running <= 1'b0;
      end else if (start_stop) begin
         case (state)
            ST_RUN: begin
               state   <= ST_STOP;
               running <= 1'b0;
            end
            default: begin
               state   <= ST_RUN;
               running <= 1'b1;
            end
         endcase
      end
   end

   assign tick = (state == ST_RUN) && (presc == PMAX);

   // Prescaler only advances in RUN, so a resume keeps the sub-tick phase.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else if (state == ST_RUN) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   // Ripple enables come from the digit values, not the counters' carry-outs.
   always_comb begin
      logic carry;
      count = '0;
      carry = tick;
      for (int i = 0; i < DIGITS; i++) begin
         count[i] = carry;
         carry    = carry && (q[i] == digit_max(i));
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      n_counter #(
         .RADIX (RADIX[i]),
         .WIDTH (BCD_W)
      ) u_digit (
         .clock (clock),
         .reset (~reset),
         .clear (clear),
         .count (count[i]),
         .q     (q[i]),
         .co    (co[i])
      );
   end

   always_comb begin
      live = '0;
      for (int i = 0; i < DIGITS; i++) begin
         live[i*BCD_W +: BCD_W] = q[i];
      end
   end

   // The top digit only carries when every digit is at terminal count.
   assign wrap = &co;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (wrap) begin
         overflow <= 1'b1;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic                    frozen;
   logic [DIGITS*BCD_W-1:0] lap_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         frozen  <= 1'b0;
         lap_reg <= '0;
      end else if (clear) begin
         frozen  <= 1'b0;
      end else if (lap) begin
         if (frozen) begin
            frozen <= 1'b0;
         end else if (state == ST_RUN) begin
            frozen  <= 1'b1;
            lap_reg <= live;
         end
      end
   end

   assign display = frozen ? lap_reg : live;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign display    = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl (TICK_DIV 4 and 1)
module tb_stopwatch_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst4, ss4, clr4, lap4, run4, ovf4;
   logic [15:0] disp4;
   logic        rst1, ss1, clr1, lap1, run1, ovf1;
   logic [15:0] disp1;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(.TICK_DIV(4)) dut4 (
      .clock      (clock),
      .reset      (rst4),
      .start_stop (ss4),
      .clear      (clr4),
      .lap        (lap4),
      .running    (run4),
      .overflow   (ovf4),
      .display    (disp4)
   );

   stopwatch_ctrl #(.TICK_DIV(1)) dut1 (
      .clock      (clock),
      .reset      (rst1),
      .start_stop (ss1),
      .clear      (clr1),
      .lap        (lap1),
      .running    (run1),
      .overflow   (ovf1),
      .display    (disp1)
   );

   // All tasks start and end just after a falling edge.
   task automatic pulse_ss4();
      ss4 = 1'b1;
      @(negedge clock);
      ss4 = 1'b0;
   endtask

   task automatic pulse_clr4();
      clr4 = 1'b1;
      @(negedge clock);
      clr4 = 1'b0;
   endtask

   task automatic pulse_lap4();
      lap4 = 1'b1;
      @(negedge clock);
      lap4 = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      rst4 = 1'b0; ss4 = 1'b1; clr4 = 1'b0; lap4 = 1'b1;
      rst1 = 1'b0; ss1 = 1'b1; clr1 = 1'b0; lap1 = 1'b0;
      cycles(2);
      checks++;
      if ({disp4, run4, ovf4} !== 18'h0) begin
         errors++;
         $display("FAIL reset_dut4 actual disp=%h run=%b ovf=%b expected 0000/0/0", disp4, run4, ovf4);
      end
      checks++;
      if ({disp1, run1, ovf1} !== 18'h0) begin
         errors++;
         $display("FAIL reset_dut1 actual disp=%h run=%b ovf=%b expected 0000/0/0", disp1, run1, ovf1);
      end
      ss4 = 1'b0; lap4 = 1'b0; ss1 = 1'b0;
      rst4 = 1'b1; rst1 = 1'b1;
      cycles(5);
      checks++;
      if ({disp4, run4, disp1, run1} !== 34'h0) begin
         errors++;
         $display("FAIL reset_idle actual d4=%h r4=%b d1=%h r1=%b expected all 0", disp4, run4, disp1, run1);
      end
   endtask

   task automatic test_run();
      pulse_clr4();
      pulse_ss4();
      cycles(39);
      checks++;
      if (disp4 !== 16'h0009) begin
         errors++;
         $display("FAIL run_39 actual=%h expected=0009", disp4);
      end
      cycles(1);
      checks++;
      if (disp4 !== 16'h0010 || run4 !== 1'b1) begin
         errors++;
         $display("FAIL run_40 actual disp=%h run=%b expected 0010/1", disp4, run4);
      end
   endtask

   task automatic test_stop_resume();
      bit held;
      pulse_clr4();
      pulse_ss4();
      cycles(29);
      checks++;
      if (disp4 !== 16'h0007) begin
         errors++;
         $display("FAIL stop_pre actual=%h expected=0007", disp4);
      end
      pulse_ss4();
      checks++;
      if (run4 !== 1'b0) begin
         errors++;
         $display("FAIL stop_running actual=%b expected=0", run4);
      end
      held = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (disp4 !== 16'h0007) held = 1'b0;
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL stop_hold actual=%h expected=0007 throughout", disp4);
      end
      pulse_ss4();
      cycles(1);
      checks++;
      if (disp4 !== 16'h0007 || run4 !== 1'b1) begin
         errors++;
         $display("FAIL resume_phase1 actual disp=%h run=%b expected 0007/1", disp4, run4);
      end
      cycles(1);
      checks++;
      if (disp4 !== 16'h0008) begin
         errors++;
         $display("FAIL resume_phase2 actual=%h expected=0008", disp4);
      end
   endtask

   task automatic test_overflow();
      clr1 = 1'b1;
      @(negedge clock);
      clr1 = 1'b0;
      ss1 = 1'b1;
      @(negedge clock);
      ss1 = 1'b0;
      cycles(100);
      checks++;
      if (disp1 !== 16'h0100) begin
         errors++;
         $display("FAIL ovf_100 actual=%h expected=0100", disp1);
      end
      cycles(5899);
      checks++;
      if (disp1 !== 16'h5999 || ovf1 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_5999 actual disp=%h ovf=%b expected 5999/0", disp1, ovf1);
      end
      cycles(1);
      checks++;
      if (disp1 !== 16'h0000 || ovf1 !== 1'b1 || run1 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_wrap actual disp=%h ovf=%b run=%b expected 0000/1/1", disp1, ovf1, run1);
      end
      cycles(1);
      checks++;
      if (disp1 !== 16'h0001 || ovf1 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky actual disp=%h ovf=%b expected 0001/1", disp1, ovf1);
      end
      clr1 = 1'b1;
      @(negedge clock);
      clr1 = 1'b0;
      checks++;
      if (disp1 !== 16'h0000 || ovf1 !== 1'b0 || run1 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear actual disp=%h ovf=%b run=%b expected 0000/0/0", disp1, ovf1, run1);
      end
   endtask

   task automatic test_clear_wins();
      bit idle;
      pulse_clr4();
      pulse_ss4();
      cycles(92);
      checks++;
      if (disp4 !== 16'h0023) begin
         errors++;
         $display("FAIL cw_pre actual=%h expected=0023", disp4);
      end
      clr4 = 1'b1;
      ss4  = 1'b1;
      @(negedge clock);
      clr4 = 1'b0;
      ss4  = 1'b0;
      checks++;
      if (disp4 !== 16'h0000 || run4 !== 1'b0) begin
         errors++;
         $display("FAIL cw_same actual disp=%h run=%b expected 0000/0", disp4, run4);
      end
      idle = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (disp4 !== 16'h0000 || run4 !== 1'b0) idle = 1'b0;
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("FAIL cw_idle actual disp=%h run=%b expected 0000/0 throughout", disp4, run4);
      end
   endtask

   task automatic test_lap();
      bit frozen_ok;
      logic [15:0] exp_mid;
      pulse_clr4();
      pulse_ss4();
      cycles(48);
      checks++;
      if (disp4 !== 16'h0012) begin
         errors++;
         $display("FAIL lap_pre actual=%h expected=0012", disp4);
      end
      pulse_lap4();
      frozen_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (disp4 !== 16'h0012) frozen_ok = 1'b0;
      end
`ifdef STOPWATCH_LAP_EN
      exp_mid = 16'h0012;
      checks++;
      if (!frozen_ok) begin
         errors++;
         $display("FAIL lap_freeze actual=%h expected=0012 throughout", disp4);
      end
`else
      exp_mid = 16'h0017;
`endif
      checks++;
      if (disp4 !== exp_mid) begin
         errors++;
         $display("FAIL lap_mid actual=%h expected=%h", disp4, exp_mid);
      end
      pulse_lap4();
      checks++;
      if (disp4 !== 16'h0017) begin
         errors++;
         $display("FAIL lap_release actual=%h expected=0017", disp4);
      end
      cycles(2);
      checks++;
      if (disp4 !== 16'h0018) begin
         errors++;
         $display("FAIL lap_live actual=%h expected=0018", disp4);
      end
   endtask

   task automatic test_async_reset();
      bit idle;
      pulse_clr4();
      pulse_ss4();
      cycles(1380);
      checks++;
      if (disp4 !== 16'h0345 || run4 !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre actual disp=%h run=%b expected 0345/1", disp4, run4);
      end
      #2;
      rst4 = 1'b0;
      #1;
      checks++;
      if ({disp4, run4, ovf4} !== 18'h0) begin
         errors++;
         $display("FAIL ar_immediate actual disp=%h run=%b ovf=%b expected 0000/0/0", disp4, run4, ovf4);
      end
      @(negedge clock);
      rst4 = 1'b1;
      idle = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if ({disp4, run4, ovf4} !== 18'h0) idle = 1'b0;
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("FAIL ar_release actual disp=%h run=%b expected idle 0000/0", disp4, run4);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_stop_resume();
      test_overflow();
      test_clear_wins();
      test_lap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
